// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned 32-bit multiply / divide / modulo unit.
// MUL is shift-add (LSB-first). DIV/MOD use restoring division (MSB-first).
// Both produce one bit per RUN cycle.
// Optional build macro MULDIV_EARLY_OUT_EN lets MUL leave RUN as soon as
// the remaining multiplier bits are all zero. DIV/MOD always take 32 cycles.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        MUL_e,
    input  logic        DIV_e,
    input  logic        MOD_e,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

    state_t      r_state;
    state_t      w_state_next;
    op_t         r_op;
    op_t         w_op_sel;

    // Shared datapath registers.
    // r_opa holds the multiplicand (shifted left) or the dividend/quotient.
    // r_opb holds the multiplier (shifted right) or the divisor.
    // r_acc holds the product accumulator or the partial remainder.
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_last;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_fits;
    logic [31:0] w_opa_next;
    logic [31:0] w_opb_next;
    logic [31:0] w_acc_next;
    logic [31:0] w_result_next;

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    // Start acceptance and op selection: MUL beats DIV beats MOD; no enable means no start.
    always_comb begin
        w_op_sel = OP_MOD;
        if (MUL_e) begin
            w_op_sel = OP_MUL;
        end else if (DIV_e) begin
            w_op_sel = OP_DIV;
        end
        w_accept = start && (MUL_e || DIV_e || MOD_e) && (r_state != S_RUN);
    end

    // One iteration step.
    // The shifted partial remainder is 33 bits wide. The kept remainder
    // is always below the divisor, so it fits back into 32 bits.
    always_comb begin
        w_rem_sh = {r_acc, r_opa[31]};
        w_diff   = w_rem_sh - {1'b0, r_opb};
        w_fits   = ~w_diff[32];
        if (r_op == OP_MUL) begin
            w_acc_next = r_acc + (r_opb[0] ? r_opa : 32'd0);
            w_opa_next = {r_opa[30:0], 1'b0};
            w_opb_next = {1'b0, r_opb[31:1]};
        end else begin
            w_acc_next = w_fits ? w_diff[31:0] : w_rem_sh[31:0];
            w_opa_next = {r_opa[30:0], w_fits};
            w_opb_next = r_opb;
        end
        case (r_op)
            OP_MUL:  w_result_next = w_acc_next;
            OP_DIV:  w_result_next = w_opa_next;
            default: w_result_next = w_acc_next;
        endcase
    end

    // Decide whether the current RUN cycle is the final iteration.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        if (r_op == OP_MUL) begin
            w_last = (r_opb[31:1] == 31'd0);
        end else begin
            w_last = (r_cnt == 6'd31);
        end
`else
        w_last = (r_cnt == 6'd31);
`endif
    end

    // Next-state logic for the IDLE / RUN / DONE sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latch operands on accept, iterate in RUN, capture result on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op  <= w_op_sel;
            r_opa <= operand1;
            r_opb <= operand2;
            r_acc <= 32'd0;
            r_cnt <= 6'd0;
        end else if (r_state == S_RUN) begin
            r_opa <= w_opa_next;
            r_opb <= w_opb_next;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
                r_result <= w_result_next;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit.
// The bench keeps a transaction-level model: each accepted op yields its
// arithmetic result and its RUN length. The model is checked against
// busy/done/result on every cycle. Directed ops also check hand-computed
// results and latencies.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        MUL_e;
    logic        DIV_e;
    logic        MOD_e;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int n_done = 0;

    // Model state
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pend   = 32'd0;

    muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MUL_e    (MUL_e),
        .DIV_e    (DIV_e),
        .MOD_e    (MOD_e),
        .operand1 (operand1),
        .operand2 (operand2),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int mul_runs(input logic [31:0] b);
        int r;
        r = 1;
        if (!EO) return 32;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) r = i + 1;
        end
        return r;
    endfunction

    // Model: advance one clock edge using plain arithmetic per operation.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_left   = 0;
            m_done   = 1'b0;
            m_result = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) m_result = m_pend;
        end else begin
            m_done = 1'b0;
            if (start && (MUL_e || DIV_e || MOD_e)) begin
                if (MUL_e) begin
                    m_pend = operand1 * operand2;
                    m_left = mul_runs(operand2);
                end else if (DIV_e) begin
                    m_pend = (operand2 == 0) ? 32'hFFFF_FFFF : operand1 / operand2;
                    m_left = 32;
                end else begin
                    m_pend = (operand2 == 0) ? operand1 : operand1 % operand2;
                    m_left = 32;
                end
            end
        end
    end

    // Compare process: check the DUT against the model on every cycle, away from the edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("result", result, m_result);
            if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
        end
        if (done) n_done++;
    end

    // Drive one start for a single cycle; return at the negedge after the accept edge.
    task automatic issue(input logic m, input logic d, input logic o,
                         input logic [31:0] a, input logic [31:0] b);
        MUL_e = m; DIV_e = d; MOD_e = o;
        operand1 = a; operand2 = b;
        start = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        start = 1'b0;
        MUL_e = 1'b0; DIV_e = 1'b0; MOD_e = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] exp, input int lat, input string nm);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, "_result"}, result, exp);
        chk({nm, "_latency"}, cyc - acc_cyc, lat);
        $display("op %s: result=0x%08h latency=%0d", nm, result, cyc - acc_cyc);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0;
        MUL_e = 1'b0; DIV_e = 1'b0; MOD_e = 1'b0;
        operand1 = 32'd0; operand2 = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 1'b0, 1'b0, 32'd7, 32'd6);
        wait_done(32'd42, EO ? 3 : 32, "mul_7x6");
        @(negedge clk);

        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        wait_done(32'hFFFF_FFFE, EO ? 2 : 32, "mul_wrap");
        @(negedge clk);

        nd = n_done;
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(32'd14, 32, "div_100_7");
        issue(1'b0, 1'b0, 1'b1, 32'd100, 32'd7);
        wait_done(32'd2, 32, "mod_100_7_b2b");
        @(negedge clk);
        chk("b2b_done_pulses", n_done - nd, 32'd2);

        issue(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        wait_done(32'hFFFF_FFFF, 32, "div_5_0");
        issue(1'b0, 1'b0, 1'b1, 32'd5, 32'd0);
        wait_done(32'd5, 32, "mod_5_0");
        @(negedge clk);

        nd = n_done;
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        operand1 = 32'd9; operand2 = 32'd3; DIV_e = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; DIV_e = 1'b0;
        wait_done(32'd14, 32, "div_midrun_start");
        repeat (2) @(negedge clk);
        chk("midrun_done_pulses", n_done - nd, 32'd1);

        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        nd = n_done;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done - nd, 32'd0);
        $display("op abort: reset during RUN, result=0x%08h", result);

        issue(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        wait_done(32'd15, EO ? 3 : 32, "mul_3x5");
        @(negedge clk);

        nd = n_done;
        MUL_e = 1'b0; DIV_e = 1'b0; MOD_e = 1'b0;
        operand1 = 32'd4; operand2 = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("noen_busy", {31'd0, busy}, 32'd0);
        chk("noen_no_done", n_done - nd, 32'd0);
        chk("noen_result_held", result, 32'd15);
        $display("op no_enable_start: ignored, busy=%0d", busy);

        issue(1'b1, 1'b1, 1'b0, 32'd8, 32'd2);
        wait_done(32'd16, EO ? 2 : 32, "mul_priority");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
